// File: rtl/fwd_sel_ctrl_pkg.sv
// fwd_sel_ctrl_pkg: shared forwarding select codes, register width and tracking-entry type
package fwd_sel_ctrl_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXMEM  = 2'b01,
    FWD_MEMWB  = 2'b10,
    FWD_POSTWB = 2'b11
  } fwd_sel_e;
  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic [REG_AW-1:0] wd;
    logic              load;
  } trk_t;
  function automatic logic hit(trk_t e, logic [REG_AW-1:0] r);
    return e.valid & e.wreg & (|e.wd) & (e.wd == r);
  endfunction
endpackage

// File: rtl/fwd_sel_ctrl_if.sv
// fwd_sel_ctrl_if: ID-stage fields, pipeline controls and forwarding/stall results
interface fwd_sel_ctrl_if;
  import fwd_sel_ctrl_pkg::*;
  logic              hold_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_wreg_i;
  logic [REG_AW-1:0] id_wd_i;
  logic              id_load_i;
  logic [1:0]        fwd_a_sel_o;
  logic [1:0]        fwd_b_sel_o;
  logic              stall_o;
  modport master (
    output hold_i, flush_i, id_valid_i, id_rs_i, id_rt_i, id_wreg_i, id_wd_i, id_load_i,
    input  fwd_a_sel_o, fwd_b_sel_o, stall_o
  );
  modport slave (
    input  hold_i, flush_i, id_valid_i, id_rs_i, id_rt_i, id_wreg_i, id_wd_i, id_load_i,
    output fwd_a_sel_o, fwd_b_sel_o, stall_o
  );
endinterface

// File: rtl/fwd_prio_match.sv
// fwd_prio_match: nearest-first forwarding source for one operand register
module fwd_prio_match
  import fwd_sel_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  trk_t              ex,
  input  trk_t              mem,
  input  trk_t              wb,
  output fwd_sel_e          sel
);
  assign sel = hit(ex, src)  ? FWD_EXMEM  :
               hit(mem, src) ? FWD_MEMWB  :
               hit(wb, src)  ? FWD_POSTWB : FWD_RF;
endmodule

// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: registered EX operand forwarding selects and load-use stall detection
module fwd_sel_ctrl
  import fwd_sel_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fwd_sel_ctrl_if.slave      bus
);
  trk_t     ex, mem, wb, nxt;
  fwd_sel_e a_m, b_m, a_d, b_d, a_q, b_q;
  logic     stall, kill;
  fwd_prio_match u_a (.src(bus.id_rs_i), .ex(ex), .mem(mem), .wb(wb), .sel(a_m));
  fwd_prio_match u_b (.src(bus.id_rt_i), .ex(ex), .mem(mem), .wb(wb), .sel(b_m));
  assign a_d   = bus.id_valid_i ? a_m : FWD_RF;
  assign b_d   = bus.id_valid_i ? b_m : FWD_RF;
  assign stall = bus.id_valid_i & ex.load & (hit(ex, bus.id_rs_i) | hit(ex, bus.id_rt_i));
  assign kill  = bus.flush_i | stall;
  // squashed or stalled instructions enter EX as bubbles that never match
  assign nxt   = '{valid: bus.id_valid_i & ~kill, wreg: bus.id_wreg_i, wd: bus.id_wd_i, load: bus.id_load_i};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
      a_q <= FWD_RF;
      b_q <= FWD_RF;
    end else if (!bus.hold_i) begin
      ex  <= nxt;
      mem <= ex;
      wb  <= mem;
      a_q <= kill ? FWD_RF : a_d;
      b_q <= kill ? FWD_RF : b_d;
    end
  end
  assign bus.fwd_a_sel_o = a_q;
  assign bus.fwd_b_sel_o = b_q;
  assign bus.stall_o     = stall;
endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb_fwd_sel_ctrl: directed vector table plus reset-during-stall sequence
module tb_fwd_sel_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  fwd_sel_ctrl_if bus();
  fwd_sel_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int v, rs, rt, w, wd, ld, hd, fl, st, a, b;
  } vec_t;
  vec_t vt[27];
  task automatic chk(string nm, int idx, logic [1:0] act, int exp);
    checks++;
    if (act !== 2'(exp)) begin
      errors++;
      $display("FAIL %s vec %0d got %0d want %0d", nm, idx, act, exp);
    end
  endtask
  task automatic drive(vec_t x);
    bus.id_valid_i = x.v[0];
    bus.id_rs_i    = 5'(x.rs);
    bus.id_rt_i    = 5'(x.rt);
    bus.id_wreg_i  = x.w[0];
    bus.id_wd_i    = 5'(x.wd);
    bus.id_load_i  = x.ld[0];
    bus.hold_i     = x.hd[0];
    bus.flush_i    = x.fl[0];
  endtask
  task automatic step(vec_t x, int idx);
    drive(x);
    #2;
    chk("stall", idx, {1'b0, bus.stall_o}, x.st);
    @(posedge clk);
    #1;
    chk("sel_a", idx, bus.fwd_a_sel_o, x.a);
    chk("sel_b", idx, bus.fwd_b_sel_o, x.b);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 3, 5, 1, 4, 0, 0, 0, 0, 1, 0};
    vt[2]  = '{1, 1, 2, 1, 7, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{1, 1, 2, 1, 10, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{1, 1, 7, 1, 11, 0, 0, 0, 0, 0, 2};
    vt[5]  = '{1, 1, 7, 1, 12, 0, 0, 0, 0, 0, 3};
    vt[6]  = '{1, 1, 2, 1, 7, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{1, 7, 7, 1, 13, 0, 0, 0, 0, 1, 1};
    vt[8]  = '{1, 1, 2, 1, 7, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{1, 1, 7, 1, 15, 0, 0, 0, 0, 0, 1};
    vt[10] = '{1, 1, 2, 1, 8, 1, 0, 0, 0, 0, 0};
    vt[11] = '{1, 8, 8, 1, 9, 0, 0, 0, 1, 0, 0};
    vt[12] = '{1, 8, 8, 1, 9, 0, 0, 0, 0, 2, 2};
    vt[13] = '{1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0};
    vt[14] = '{1, 0, 0, 1, 16, 0, 0, 0, 0, 0, 0};
    vt[15] = '{1, 1, 2, 0, 17, 1, 0, 0, 0, 0, 0};
    vt[16] = '{1, 17, 17, 1, 18, 0, 0, 0, 0, 0, 0};
    vt[17] = '{1, 1, 2, 1, 20, 1, 0, 0, 0, 0, 0};
    vt[18] = '{1, 20, 18, 1, 21, 0, 0, 1, 1, 0, 0};
    vt[19] = '{1, 18, 20, 1, 22, 0, 0, 0, 0, 3, 2};
    vt[20] = '{1, 21, 20, 1, 23, 0, 0, 0, 0, 0, 3};
    vt[21] = '{1, 23, 22, 1, 24, 0, 1, 0, 0, 0, 3};
    vt[22] = '{1, 23, 22, 1, 24, 0, 1, 0, 0, 0, 3};
    vt[23] = '{1, 23, 22, 1, 24, 0, 1, 0, 0, 0, 3};
    vt[24] = '{1, 23, 22, 1, 24, 0, 0, 0, 0, 1, 2};
    vt[25] = '{1, 22, 24, 1, 25, 0, 0, 0, 0, 3, 1};
    vt[26] = '{0, 24, 25, 1, 0, 0, 0, 0, 0, 0, 0};
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #12;
    chk("rst_stall", -1, {1'b0, bus.stall_o}, 0);
    chk("rst_a", -1, bus.fwd_a_sel_o, 0);
    chk("rst_b", -1, bus.fwd_b_sel_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 27; i++) step(vt[i], i);
    step('{1, 25, 2, 1, 26, 1, 0, 0, 0, 2, 0}, 27);
    drive('{1, 26, 26, 1, 27, 0, 0, 0, 0, 0, 0});
    #2;
    chk("midstall_pre", 28, {1'b0, bus.stall_o}, 1);
    rst_n = 1'b0;
    #1;
    chk("midstall_stall", 28, {1'b0, bus.stall_o}, 0);
    chk("midstall_a", 28, bus.fwd_a_sel_o, 0);
    chk("midstall_b", 28, bus.fwd_b_sel_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step('{1, 26, 26, 1, 27, 0, 0, 0, 0, 0, 0}, 29);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
